// File: rtl/player_motion_pkg.sv
// -----------------------------------------------------------------------------
// player_motion_pkg
// Shared definitions for the per-player motion engine and its consumers.
// The board draw FSM imports BOARD_MAX from here for its position-to-address
// logic, so the board edge is defined in exactly one place.
//   motion_state_t : step engine states (IDLE, STEP_X, STEP_Y, DONE)
//   DIR_*          : impulse direction codes carried on `dir`
//   BOARD_MAX      : highest legal row/column index on the 16x16 board
// -----------------------------------------------------------------------------
package player_motion_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP_X = 2'd1,
      STEP_Y = 2'd2,
      DONE   = 2'd3
   } motion_state_t;

   localparam logic [1:0] DIR_UP    = 2'd0;  // Y - 1
   localparam logic [1:0] DIR_DOWN  = 2'd1;  // Y + 1
   localparam logic [1:0] DIR_LEFT  = 2'd2;  // X - 1
   localparam logic [1:0] DIR_RIGHT = 2'd3;  // X + 1

   localparam logic [3:0] BOARD_MAX = 4'd15;

endpackage

// File: rtl/motion_tick_divider.sv
// -----------------------------------------------------------------------------
// motion_tick_divider
// Free-running clock divider that produces the one-cycle motion tick.
// The count advances only while `enable` is high; the tick is raised in the
// cycle where the count equals TICK_DIV-1, after which the count wraps to 0.
// Ports:
//   clock  in  : system clock
//   reset  in  : asynchronous active-low reset (count cleared)
//   enable in  : count advances / tick allowed only while high
//   tick   out : one-cycle pulse every TICK_DIV enabled cycles
// -----------------------------------------------------------------------------
module motion_tick_divider
   import player_motion_pkg::*;
#(
   parameter int TICK_DIV = 6250000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

   assign tick = enable && (count == LAST);

endmodule

// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
// Momentum and position engine for one player. Direction impulses adjust a
// signed per-axis velocity; once per motion tick the engine walks the 4-bit
// board position one cell per cycle (X axis first, then Y), then applies
// friction and any impulse that arrived while it was busy.
//
// Build option: PLAYER_MOTION_BOUNCE_EN
//   defined   : hitting a wall negates that axis velocity (position stays put)
//   undefined : hitting a wall zeroes that axis velocity
//
// Strobe semantics: dir_valid and pos_valid are single-cycle qualifiers with
// no back-pressure. dir/dir_valid are sampled on every rising clock edge and
// are never refused; pos_valid marks the one cycle in which pos_X/pos_Y hold a
// settled result, and the position then stays stable until the next tick.
//
// Ports:
//   clock     in  : system clock
//   reset     in  : asynchronous active-low reset
//   enable    in  : gates the tick divider; low means no new step begins
//   load      in  : synchronous return to START, velocity/pending/friction clear
//   dir_valid in  : one-cycle impulse strobe
//   dir       in  : impulse direction (DIR_UP/DOWN/LEFT/RIGHT)
//   pos_X     out : current column 0..15
//   pos_Y     out : current row 0..15
//   vel_X     out : signed X velocity, VW bits
//   vel_Y     out : signed Y velocity, VW bits
//   pos_valid out : one-cycle strobe in the DONE cycle
//   busy      out : high in every state except IDLE
//   fsm_state out : current step-engine state (debug visibility)
// -----------------------------------------------------------------------------
module player_motion
   import player_motion_pkg::*;
#(
   parameter  int TICK_DIV       = 6250000,
   parameter  int MAX_SPEED      = 3,
   parameter  int FRICTION_TICKS = 4,
   parameter  int START_X        = 0,
   parameter  int START_Y        = 0,
   localparam int VW             = $clog2(MAX_SPEED + 1) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          load,
   input  logic          dir_valid,
   input  logic [1:0]    dir,
   output logic [3:0]    pos_X,
   output logic [3:0]    pos_Y,
   output logic [VW-1:0] vel_X,
   output logic [VW-1:0] vel_Y,
   output logic          pos_valid,
   output logic          busy,
   output logic [1:0]    fsm_state
);

   localparam int FCW = (FRICTION_TICKS > 1) ? $clog2(FRICTION_TICKS) : 1;
   localparam logic signed [VW-1:0] VMAX = VW'(MAX_SPEED);
   localparam logic signed [VW-1:0] VMIN = VW'(-MAX_SPEED);

   // ---------------------------------------------------------------------------
   // Velocity helpers
   // ---------------------------------------------------------------------------
   // One unit toward +/- with saturation at the speed limit.
   function automatic logic signed [VW-1:0] nudge(input logic signed [VW-1:0] v,
                                                   input logic inc);
      logic signed [VW-1:0] r;
      if (inc) r = (v >= VMAX) ? VMAX : v + VW'(1);
      else     r = (v <= VMIN) ? VMIN : v - VW'(1);
      return r;
   endfunction

   function automatic logic signed [VW-1:0] impulse_x(input logic signed [VW-1:0] v,
                                                       input logic [1:0] d);
      logic signed [VW-1:0] r;
      r = v;
      if (d == DIR_LEFT)  r = nudge(v, 1'b0);
      if (d == DIR_RIGHT) r = nudge(v, 1'b1);
      return r;
   endfunction

   function automatic logic signed [VW-1:0] impulse_y(input logic signed [VW-1:0] v,
                                                       input logic [1:0] d);
      logic signed [VW-1:0] r;
      r = v;
      if (d == DIR_UP)   r = nudge(v, 1'b0);
      if (d == DIR_DOWN) r = nudge(v, 1'b1);
      return r;
   endfunction

   function automatic logic signed [VW-1:0] toward_zero(input logic signed [VW-1:0] v);
      logic signed [VW-1:0] r;
      r = v;
      if (v != '0) r = v[VW-1] ? v + VW'(1) : v - VW'(1);
      return r;
   endfunction

   // Speed limit keeps |v| below 2^(VW-1), so negation never overflows.
   function automatic logic [VW-1:0] magnitude(input logic signed [VW-1:0] v);
      return v[VW-1] ? VW'(-v) : v;
   endfunction

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   motion_state_t state, state_next;

   logic [3:0]           pos_x_q, pos_y_q;
   logic signed [VW-1:0] vel_x_q, vel_y_q;
   logic [VW-1:0]        rem_x, rem_y;
   logic                 pend_valid;
   logic [1:0]           pend_dir;
   logic [FCW-1:0]       fric_cnt;
   logic                 tick;

   motion_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   // ---------------------------------------------------------------------------
   // Combinational datapath terms
   // ---------------------------------------------------------------------------
   logic                 x_neg, y_neg, x_wall, y_wall;
   logic signed [VW-1:0] wall_vel_x, wall_vel_y;
   logic signed [VW-1:0] idle_vel_x, idle_vel_y;
   logic signed [VW-1:0] decay_x, decay_y, done_vel_x, done_vel_y;
   logic                 fric_hit, use_imp;
   logic [1:0]           use_dir;

   assign x_neg  = vel_x_q[VW-1];
   assign y_neg  = vel_y_q[VW-1];
   assign x_wall = x_neg ? (pos_x_q == 4'd0) : (pos_x_q == BOARD_MAX);
   assign y_wall = y_neg ? (pos_y_q == 4'd0) : (pos_y_q == BOARD_MAX);

`ifdef PLAYER_MOTION_BOUNCE_EN
   assign wall_vel_x = -vel_x_q;
   assign wall_vel_y = -vel_y_q;
`else
   assign wall_vel_x = '0;
   assign wall_vel_y = '0;
`endif

   // In IDLE an impulse lands on the same edge as a tick, so the step
   // distance is taken from the already-updated velocity.
   assign idle_vel_x = dir_valid ? impulse_x(vel_x_q, dir) : vel_x_q;
   assign idle_vel_y = dir_valid ? impulse_y(vel_y_q, dir) : vel_y_q;

   // DONE: friction first, then the newest impulse (one arriving in the DONE
   // cycle itself overrides the stored one).
   assign fric_hit   = (fric_cnt == FCW'(FRICTION_TICKS - 1));
   assign decay_x    = fric_hit ? toward_zero(vel_x_q) : vel_x_q;
   assign decay_y    = fric_hit ? toward_zero(vel_y_q) : vel_y_q;
   assign use_imp    = dir_valid | pend_valid;
   assign use_dir    = dir_valid ? dir : pend_dir;
   assign done_vel_x = use_imp ? impulse_x(decay_x, use_dir) : decay_x;
   assign done_vel_y = use_imp ? impulse_y(decay_y, use_dir) : decay_y;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      pos_valid  = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (tick) state_next = STEP_X;
         STEP_X:  if (rem_x == '0) state_next = STEP_Y;
         STEP_Y:  if (rem_y == '0) state_next = DONE;
         DONE: begin
            pos_valid  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // load abandons the step outright, so no result is announced.
      if (load) begin
         state_next = IDLE;
         pos_valid  = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pos_x_q    <= 4'(START_X);
         pos_y_q    <= 4'(START_Y);
         vel_x_q    <= '0;
         vel_y_q    <= '0;
         rem_x      <= '0;
         rem_y      <= '0;
         pend_valid <= 1'b0;
         pend_dir   <= DIR_UP;
         fric_cnt   <= '0;
      end else if (load) begin
         pos_x_q    <= 4'(START_X);
         pos_y_q    <= 4'(START_Y);
         vel_x_q    <= '0;
         vel_y_q    <= '0;
         rem_x      <= '0;
         rem_y      <= '0;
         pend_valid <= 1'b0;
         pend_dir   <= DIR_UP;
         fric_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               vel_x_q <= idle_vel_x;
               vel_y_q <= idle_vel_y;
               if (tick) begin
                  rem_x <= magnitude(idle_vel_x);
                  rem_y <= magnitude(idle_vel_y);
               end
            end
            STEP_X: begin
               if (dir_valid) begin
                  pend_valid <= 1'b1;
                  pend_dir   <= dir;
               end
               if (rem_x != '0) begin
                  // A wall hit spends this cycle and ends the axis.
                  if (x_wall) begin
                     vel_x_q <= wall_vel_x;
                     rem_x   <= '0;
                  end else begin
                     pos_x_q <= x_neg ? pos_x_q - 4'd1 : pos_x_q + 4'd1;
                     rem_x   <= rem_x - VW'(1);
                  end
               end
            end
            STEP_Y: begin
               if (dir_valid) begin
                  pend_valid <= 1'b1;
                  pend_dir   <= dir;
               end
               if (rem_y != '0) begin
                  if (y_wall) begin
                     vel_y_q <= wall_vel_y;
                     rem_y   <= '0;
                  end else begin
                     pos_y_q <= y_neg ? pos_y_q - 4'd1 : pos_y_q + 4'd1;
                     rem_y   <= rem_y - VW'(1);
                  end
               end
            end
            DONE: begin
               vel_x_q    <= done_vel_x;
               vel_y_q    <= done_vel_y;
               pend_valid <= 1'b0;
               fric_cnt   <= fric_hit ? '0 : fric_cnt + FCW'(1);
            end
            default: ;
         endcase
      end
   end

   assign pos_X     = pos_x_q;
   assign pos_Y     = pos_y_q;
   assign vel_X     = vel_x_q;
   assign vel_Y     = vel_y_q;
   assign fsm_state = state;

endmodule

// File: tb/tb_player_motion.sv
module tb_player_motion;

   localparam int TICK_DIV       = 4;
   localparam int MAX_SPEED      = 3;
   localparam int FRICTION_TICKS = 4;
   localparam int START_X        = 0;
   localparam int START_Y        = 0;
   localparam int VW             = $clog2(MAX_SPEED + 1) + 1;
`ifdef PLAYER_MOTION_BOUNCE_EN
   localparam int WALL_VEL = -3;
`else
   localparam int WALL_VEL = 0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clock = 1'b0;
   logic          reset;
   logic          enable, load, dir_valid;
   logic [1:0]    dir;
   logic [3:0]    pos_X, pos_Y;
   logic [VW-1:0] vel_X, vel_Y;
   logic          pos_valid, busy;
   logic [1:0]    fsm_state;

   always #5 clock = ~clock;

   player_motion #(
      .TICK_DIV(TICK_DIV), .MAX_SPEED(MAX_SPEED), .FRICTION_TICKS(FRICTION_TICKS),
      .START_X(START_X), .START_Y(START_Y)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .load(load),
      .dir_valid(dir_valid), .dir(dir), .pos_X(pos_X), .pos_Y(pos_Y),
      .vel_X(vel_X), .vel_Y(vel_Y), .pos_valid(pos_valid), .busy(busy),
      .fsm_state(fsm_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];   // expected {pos_X, pos_Y} per announced step

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Whole step is resolved at the tick; only its duration is tracked after.
   int m_px, m_py, m_vx, m_vy, m_fric, m_dcnt, m_left, m_phase, m_pend_d;
   bit m_pend;

   function automatic int sat(input int v);
      if (v > MAX_SPEED)  return MAX_SPEED;
      if (v < -MAX_SPEED) return -MAX_SPEED;
      return v;
   endfunction

   function automatic int decay(input int v);
      if (v > 0) return v - 1;
      if (v < 0) return v + 1;
      return 0;
   endfunction

   task automatic model_impulse(input int d);
      case (d)
         0:       m_vy = sat(m_vy - 1);
         1:       m_vy = sat(m_vy + 1);
         2:       m_vx = sat(m_vx - 1);
         default: m_vx = sat(m_vx + 1);
      endcase
   endtask

   // Walk one axis: returns final position, velocity and cycles spent.
   task automatic axis_step(input int p0, input int v0, output int p, output int v,
                            output int cyc);
      int s, n;
      p = p0; v = v0; cyc = 1;
      n = (v0 < 0) ? -v0 : v0;
      s = (v0 < 0) ? -1 : 1;
      for (int k = 0; k < n; k++) begin
         if ((s < 0 && p == 0) || (s > 0 && p == 15)) begin
`ifdef PLAYER_MOTION_BOUNCE_EN
            v = -v0;
`else
            v = 0;
`endif
            cyc++;
            break;
         end
         p += s;
         cyc++;
      end
   endtask

   task automatic model_clear();
      m_px = START_X; m_py = START_Y; m_vx = 0; m_vy = 0;
      m_fric = 0; m_pend = 0; m_pend_d = 0; m_left = 0; m_phase = 0;
      exp_q.delete();
   endtask

   task automatic model_reset();
      model_clear();
      m_dcnt = 0;
   endtask

   task automatic model_step();
      bit tick;
      int p, v, cx, cy;
      tick = enable && (m_dcnt == TICK_DIV - 1);
      if (enable) m_dcnt = (m_dcnt == TICK_DIV - 1) ? 0 : m_dcnt + 1;
      if (load) begin
         model_clear();
         return;
      end
      case (m_phase)
         0: begin
            if (dir_valid) model_impulse(int'(dir));
            if (tick) begin
               axis_step(m_px, m_vx, p, v, cx); m_px = p; m_vx = v;
               axis_step(m_py, m_vy, p, v, cy); m_py = p; m_vy = v;
               m_left  = cx + cy;
               m_phase = 1;
               exp_q.push_back({4'(m_px), 4'(m_py)});
            end
         end
         1: begin
            if (dir_valid) begin m_pend = 1; m_pend_d = int'(dir); end
            m_left--;
            if (m_left == 0) m_phase = 2;
         end
         default: begin
            if (dir_valid) begin m_pend = 1; m_pend_d = int'(dir); end
            m_fric++;
            if (m_fric == FRICTION_TICKS) begin
               m_fric = 0;
               m_vx = decay(m_vx);
               m_vy = decay(m_vy);
            end
            if (m_pend) model_impulse(m_pend_d);
            m_pend  = 0;
            m_phase = 0;
         end
      endcase
   endtask

   always @(posedge clock) begin
      if (!reset) model_reset();
      else        model_step();
   end

   // ---------------- per-cycle checks and driver tasks ----------------
   task automatic check_outputs();
      check("busy", int'(busy), int'(m_phase != 0));
      check("pos_valid", int'(pos_valid), int'(m_phase == 2 && !load));
      if (m_phase != 1) begin
         check("pos_x", int'(pos_X), m_px);
         check("pos_y", int'(pos_Y), m_py);
         check("vel_x", int'($signed(vel_X)), m_vx);
         check("vel_y", int'($signed(vel_Y)), m_vy);
      end
      if (pos_valid) begin
         if (exp_q.size() == 0) check("pv_unexpected", 1, 0);
         else                   check("pv_pos", int'({pos_X, pos_Y}), int'(exp_q.pop_front()));
      end
   endtask

   task automatic cyc(input bit en, input bit ld, input bit dv, input logic [1:0] d);
      @(negedge clock);
      check_outputs();
      enable = en; load = ld; dir_valid = dv; dir = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0);
   endtask

   task automatic load_pulse();
      cyc(0, 1, 0, 2'd0);
      cyc(0, 0, 0, 2'd0);
   endtask

   task automatic impulse(input logic [1:0] d, input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 1, d);
      cyc(0, 0, 0, 2'd0);
   endtask

   // Runs with enable high until pos_valid is seen (bounded); returns at that cycle.
   task automatic wait_done(output int pv_seen);
      bit seen = 0;
      pv_seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc(1, 0, 0, 2'd0);
         if (pos_valid) begin seen = 1; pv_seen++; end
      end
      check("step_done_in_time", int'(seen), 1);
   endtask

   task automatic run_step();
      int pv;
      wait_done(pv);
      cyc(0, 0, 0, 2'd0);
   endtask

   task automatic enter_step();
      int n = 0;
      while (m_phase != 1 && n < 20) begin
         cyc(1, 0, 0, 2'd0);
         n++;
      end
      check("enter_step_busy", int'(busy), 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pv;
      reset = 1'b0; enable = 1'b0; load = 1'b0; dir_valid = 1'b0; dir = 2'd0;
      model_reset();
      repeat (2) @(negedge clock);
      check("rst_pos_x", int'(pos_X), START_X);
      check("rst_pos_y", int'(pos_Y), START_Y);
      check("rst_vel_x", int'(vel_X), 0);
      check("rst_vel_y", int'(vel_Y), 0);
      check("rst_pos_valid", int'(pos_valid), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b1;
      idle(2);

      // Free motion: three RIGHT impulses, one step of +3.
      load_pulse();
      impulse(2'd3, 3);
      check("free_vel_x", int'($signed(vel_X)), 3);
      wait_done(pv);
      check("free_pos_x", int'(pos_X), 3);
      idle(1);

      // Saturation, and a tick during busy must not start another step.
      load_pulse();
      impulse(2'd3, 5);
      check("sat_vel_x", int'($signed(vel_X)), 3);
      wait_done(pv);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 2'd0);
         if (pos_valid) pv++;
      end
      check("drop_one_pos_valid", pv, 1);

      // Wall: reach column 14 with vel 3, then hit the right wall.
      load_pulse();
      impulse(2'd3, 3);
      for (int i = 0; i < 5; i++) run_step();
      impulse(2'd3, 1);
      check("wall_pre_pos_x", int'(pos_X), 14);
      check("wall_pre_vel_x", int'($signed(vel_X)), 3);
      run_step();
      check("wall_pos_x", int'(pos_X), 15);
      check("wall_vel_x", int'($signed(vel_X)), WALL_VEL);

      // Friction: vel_Y 2 decays to 1 after the fourth step.
      load_pulse();
      impulse(2'd1, 2);
      for (int i = 0; i < 4; i++) run_step();
      check("fric_pos_y", int'(pos_Y), 8);
      check("fric_vel_y", int'($signed(vel_Y)), 1);

      // Pending impulse: LEFT during STEP_X applies only in DONE.
      load_pulse();
      impulse(2'd3, 2);
      enter_step();
      cyc(1, 0, 1, 2'd2);
      wait_done(pv);
      check("pend_pos_x", int'(pos_X), 2);
      idle(1);
      check("pend_vel_x", int'($signed(vel_X)), 1);

      // Asynchronous reset in the middle of STEP_Y.
      load_pulse();
      impulse(2'd1, 2);
      enter_step();
      cyc(0, 0, 0, 2'd0);
      reset = 1'b0;
      #1;
      model_reset();
      check("mid_rst_pos_y", int'(pos_Y), START_Y);
      check("mid_rst_vel_y", int'(vel_Y), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_pos_valid", int'(pos_valid), 0);
      @(negedge clock);
      reset = 1'b1;
      idle(2);

      // load in the middle of a step: no announcement, back to START.
      impulse(2'd1, 2);
      impulse(2'd3, 1);
      enter_step();
      cyc(1, 1, 0, 2'd0);
      pv = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 2'd0);
         if (pos_valid) pv++;
      end
      check("load_no_pos_valid", pv, 0);
      check("load_pos_x", int'(pos_X), START_X);
      check("load_pos_y", int'(pos_Y), START_Y);
      check("load_vel_x", int'(vel_X), 0);
      check("load_vel_y", int'(vel_Y), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
      end
      idle(15);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/player_motion.md
# player_motion

Per-player momentum and position engine. Sits directly upstream of the game-board draw FSM: it turns direction impulses into a signed velocity per axis, advances a 4-bit board position once per motion tick, and drives the `red_X/red_Y` or `blue_X/blue_Y` inputs of the board FSM. Each player has one instance. `pos_valid` is a one-cycle strobe that marks a settled position the board FSM can sample.

## Interface
- `TICK_DIV`, 6250000: clock cycles per motion tick (8 Hz at 50 MHz).
- `MAX_SPEED`, 3: velocity magnitude limit in cells per tick; legal range 1..7.
- `FRICTION_TICKS`, 4: number of motion ticks between each friction decay.
- `START_X`, 0: X position loaded on reset and on `load`.
- `START_Y`, 0: Y position loaded on reset and on `load`.
- `clock` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, the tick divider holds and no new step begins.
- `load` in 1: synchronous; returns the position to `START_X/START_Y` and clears velocity.
- `dir_valid` in 1: one-cycle direction impulse strobe.
- `dir` in 2: impulse direction; 0 = UP (Y−1), 1 = DOWN (Y+1), 2 = LEFT (X−1), 3 = RIGHT (X+1).
- `pos_X` out 4: current column, 0..15.
- `pos_Y` out 4: current row, 0..15.
- `vel_X` out VW: signed X velocity, where VW = $clog2(MAX_SPEED+1)+1.
- `vel_Y` out VW: signed Y velocity.
- `pos_valid` out 1: one-cycle strobe after each completed step.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, STEP_X, STEP_Y, DONE.
- IDLE, on a tick with `enable` high:
  - latch `rem_x = |vel_X|` and `rem_y = |vel_Y|`;
  - go to STEP_X.
- STEP_X, one cell per cycle:
  - if `rem_x == 0`, go to STEP_Y;
  - else if `pos_X` is at the wall in the direction of motion (0 when moving negative, 15 when moving positive), apply the wall rule and force `rem_x` to 0;
  - else move `pos_X` by ±1 and decrement `rem_x`.
- STEP_Y: identical rules on the Y axis; when `rem_y == 0`, go to DONE.
- DONE:
  - increment the friction counter; when it reaches `FRICTION_TICKS`, clear it and move each non-zero velocity 1 toward 0;
  - apply any pending impulse;
  - pulse `pos_valid`;
  - return to IDLE.
- Impulse handling:
  - In IDLE, `dir_valid` updates the velocity on the same clock edge.
  - In any other state, the impulse is stored in a one-entry pending register. A newer impulse overwrites an older one. The pending impulse is applied in DONE, after friction.
- Velocity saturates at ±`MAX_SPEED`; it never wraps.
- Wall rule (default): the velocity on that axis becomes 0.
- `load` has priority over everything in every state:
  - position goes to START, both velocities to 0;
  - the pending impulse and friction counter are cleared;
  - the state goes to IDLE and `pos_valid` stays low.
- A tick that arrives while the FSM is not in IDLE is dropped. It is not queued.

## Timing
- Reset values:
  - `pos_X = START_X`, `pos_Y = START_Y`;
  - `vel_X = vel_Y = 0`;
  - `pos_valid = 0`, `busy = 0`;
  - state IDLE;
  - tick divider, friction counter and pending register all cleared.
- The tick is a one-cycle pulse when the divider counter equals `TICK_DIV−1`; the counter then wraps to 0.
- Latency from the tick to `pos_valid` is |vel_X| + |vel_Y| + 3 cycles. This is 3 cycles at zero velocity and 2·MAX_SPEED + 3 cycles at most.
- `pos_X/pos_Y` are stable from the `pos_valid` cycle until the next tick.
- An impulse in IDLE is visible on `vel_*` in the next cycle.
- A simultaneous tick and impulse in IDLE: the impulse is applied first, and the step uses the updated velocity.
- A wall hit costs one cycle on that axis.

## Configuration
- `PLAYER_MOTION_BOUNCE_EN`:
  - defined: the wall rule negates the velocity on that axis instead of zeroing it, and the position stays at the wall for this tick;
  - undefined: the velocity is zeroed at the wall.
- All other behaviour is identical in both builds.

## Structure
- Package `player_motion_pkg` holds:
  - the state enum;
  - the `dir` code constants (`DIR_UP`, `DIR_DOWN`, `DIR_LEFT`, `DIR_RIGHT`);
  - `BOARD_MAX = 15`.
- The board FSM's position-to-address logic also imports `BOARD_MAX` from this package.
- Sub-module `motion_tick_divider`: a parameterised counter with `enable` and the asynchronous active-low reset, producing the one-cycle tick.

## Test plan
All scenarios use `TICK_DIV=4`, `MAX_SPEED=3`, `FRICTION_TICKS=4`, `START=(0,0)`.
- Free motion: 3× RIGHT in IDLE → `vel_X = 3`; the next tick gives `pos_X` 0→3, with `pos_valid` 6 cycles after the tick.
- Saturation and drop: 5× RIGHT → `vel_X = 3`. A tick asserted while `busy` → no extra step; exactly one `pos_valid`.
- Wall:
  - default build: `pos_X = 14`, `vel_X = 3`, tick → `pos_X = 15`, `vel_X = 0`;
  - with `PLAYER_MOTION_BOUNCE_EN`: same stimulus → `pos_X = 15`, `vel_X = −3`.
- Friction: DOWN ×2, then 4 ticks with no impulse → `pos_Y = 8`, `vel_Y = 1` after the 4th `pos_valid`.
- Pending impulse: LEFT asserted during STEP_X with `vel_X = 2` → the step completes at +2, then `vel_X = 1` in DONE.
- Reset and load: drive `reset` low mid-STEP_Y → outputs return to reset values immediately. `load` mid-step → `pos = (0,0)`, `vel = 0`, no `pos_valid`.
